// File: rtl/rv32i_types.sv
// Shared types for the rv32i datapath and its memory-side blocks.
// Contents:
//   arb_state_t - state encoding of the two-to-one memory arbiter
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-to-one memory arbiter between the datapath's instruction-fetch port
// and data port, serialized onto one shared word-wide memory port with one
// outstanding transaction at a time. Data requests win by default; a
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants taken while a fetch was waiting.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   inst_read/inst_addr      fetch request (held until inst_resp)
//   inst_resp/inst_rdata     one-cycle fetch completion and data
//   data_read/data_write     load/store request (held until data_resp)
//   data_mbe/data_addr/data_wdata  store byte enables, address, store data
//   data_resp/data_rdata     one-cycle data completion and load data
//   mem_read/mem_write       shared-port commands (registered)
//   mem_mbe/mem_addr/mem_wdata  shared-port byte enables, word address, data
//   mem_resp/mem_rdata       shared-port completion and read data
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winning request
// I_BUSY | fetch outstanding on the shared port
// D_BUSY | load or store outstanding on the shared port
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_resp,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_resp,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_mbe,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             data_req;
  logic             grant_inst;
  logic             grant_data;

  assign data_req = data_read | data_write;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE) begin
      if (inst_read && (!data_req || starve_cnt == CNT_MAX)) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_mbe    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            state      <= I_BUSY;
            mem_read   <= 1'b1;
            mem_write  <= 1'b0;
            mem_mbe    <= '0;
            mem_addr   <= inst_addr & WORD_MASK;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else if (grant_data) begin
            // a simultaneous read+write is a store; the read is dropped
            state      <= D_BUSY;
            mem_read   <= ~data_write;
            mem_write  <= data_write;
            mem_mbe    <= data_mbe;
            mem_addr   <= data_addr & WORD_MASK;
            mem_wdata  <= data_wdata;
            if (!inst_read) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Responses are combinational from mem_resp; gating with rst keeps a
  // response from escaping in the cycle reset is asserted mid-transaction.
  always_comb begin
    inst_resp  = rst && (state == I_BUSY) && mem_resp;
    data_resp  = rst && (state == D_BUSY) && mem_resp;
    inst_rdata = inst_resp ? mem_rdata : '0;
    data_rdata = (data_resp && mem_read) ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one memory arbiter directly downstream of the pipelined datapath. Accepts the datapath's instruction-fetch port and data port and serializes them onto one shared word-wide memory port, one outstanding transaction at a time. Data requests win by default; a starvation counter guarantees instruction fetches progress. Pulses a one-cycle response back to the requesting side.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before a forced fetch grant
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- inst_read  input  1  fetch request, held until inst_resp
- inst_addr  input  ADDR_W  fetch address
- inst_resp  output  1  one-cycle fetch completion
- inst_rdata  output  DATA_W  fetch data, valid when inst_resp
- data_read  input  1  load request, held until data_resp
- data_write  input  1  store request, held until data_resp
- data_mbe  input  DATA_W/8  store byte enables
- data_addr  input  ADDR_W  load/store address
- data_wdata  input  DATA_W  store data
- data_resp  output  1  one-cycle data completion
- data_rdata  output  DATA_W  load data, valid when data_resp
- mem_read, mem_write  output  1 each  shared-port commands
- mem_mbe  output  DATA_W/8  shared-port byte enables
- mem_addr  output  ADDR_W  shared-port address, bits [1:0] always 0
- mem_wdata  output  DATA_W  shared-port store data
- mem_resp  input  1  shared-port completion
- mem_rdata  input  DATA_W  shared-port read data

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE, no request: stay IDLE.
- IDLE with one request: go to I_BUSY or D_BUSY. Latch the address, with bits [1:0] cleared. Latch the command. For data, also latch mbe and wdata.
- IDLE with both requests: grant data, unless starve_cnt == STARVE_LIMIT; then grant the fetch.
- data_read and data_write both high: treat as a write; the read is ignored.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a data grant while inst_read is high.
  - Clears to 0 on any fetch grant.
  - Clears to 0 on a data grant while inst_read is low.
- Busy states:
  - mem_* outputs are driven only from the latched registers. Requester inputs changing mid-transaction have no effect.
  - mem_read or mem_write stays high until mem_resp.
- mem_resp in I_BUSY:
  - inst_resp = 1 and inst_rdata = mem_rdata in the same cycle (combinational).
  - Next state IDLE.
- mem_resp in D_BUSY:
  - data_resp = 1 the same way; data_rdata = mem_rdata for loads.
  - Next state IDLE.
- mem_resp in IDLE: ignored, no response pulse.
- inst_rdata and data_rdata are 0 whenever their resp is low.
- Reset (rst == 0): state IDLE; all of the following are 0:
  - mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  - inst_resp, data_resp
  - starve_cnt
- Reset mid-transaction: the transaction is abandoned and no resp is generated. A late mem_resp after reset is ignored.

## Timing
- Grant latency: a request seen in IDLE at cycle N gives mem_read/mem_write high at cycle N+1 (registered).
- Response latency: zero cycles from mem_resp to inst_resp/data_resp.
- Turnaround: at least one IDLE cycle between transactions. With a 1-cycle memory, a transaction occupies 3 cycles: IDLE, BUSY+resp, IDLE.
- The arbiter never asserts mem_read and mem_write together.
- At most one of inst_resp and data_resp is high in any cycle.
- The requester must hold its inputs stable until its resp. It may change them in the cycle after resp; the arbiter re-samples only in IDLE.

## Structure
- Add arb_state_t (IDLE, I_BUSY, D_BUSY) to the shared rv32i_types package.
- No sub-module. Single module containing:
  - state register
  - request latch (addr, cmd, mbe, wdata)
  - starvation counter sized $clog2(STARVE_LIMIT+1)
  - combinational next-state/response logic

## Test plan
- Fetch only, inst_addr 0x0000_0063, memory 1-cycle latency returning 0xDEAD_BEEF:
  - mem_read high at N+1 with mem_addr 0x0000_0060.
  - inst_resp high with inst_rdata 0xDEAD_BEEF in the mem_resp cycle.
  - Then IDLE.
- Simultaneous inst_read and data_write (addr 0x100, mbe 4'b0011, wdata 0x1234_5678):
  - Store serviced first: mem_write, mbe 0011, wdata 0x1234_5678.
  - Fetch serviced after one IDLE cycle.
- Starvation, STARVE_LIMIT=4, inst_read held high while data requests are continuous: exactly 4 data grants, then a fetch grant, then starve_cnt = 0.
- Stable latch: change data_addr from 0x200 to 0x300 during D_BUSY with a 5-cycle memory latency; mem_addr stays 0x200 for all 5 cycles.
- Reset mid-transaction: pull rst low during I_BUSY, then drive a mem_resp after reset releases.
  - All outputs 0; no inst_resp.
  - State IDLE.
- Spurious responses:
  - mem_resp in IDLE: no resp pulses.
  - data_read and data_write both high: only mem_write asserted.
